// File: rtl/playback_pkg.sv
// Shared types and constants for the sample playback engine.
package playback_pkg;

    // Playback controller states.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        REQ       = 3'd1,
        WAIT_DATA = 3'd2,
        PLAY      = 3'd3,
        DRAIN     = 3'd4,
        DONE      = 3'd5
    } state_t;

    // One flash word carries this many samples, byte 0 played first.
    localparam int unsigned SAMPLES_PER_WORD = 4;

    // Signed mid-scale output driven after a clip ends.
    localparam int unsigned SILENCE = 0;

    // Width of the saturating underrun counter (optional feature).
    localparam int unsigned UNDERRUN_W = 16;

endpackage

// File: rtl/sample_playback_engine_edge_sync_detect.sv
// Two-flop synchroniser followed by a registered rising-edge pulse.
// A rising edge on async_in gives a one-cycle pulse three clocks later.
module edge_sync_detect (
    input  logic clock_in,
    input  logic reset,
    input  logic async_in,
    output logic pulse
);

    logic sync_1;
    logic sync_2;
    logic sync_prev;

    // Synchronise the asynchronous level and register the edge pulse.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            sync_1    <= 1'b0;
            sync_2    <= 1'b0;
            sync_prev <= 1'b0;
            pulse     <= 1'b0;
        end else begin
            sync_1    <= async_in;
            sync_2    <= sync_1;
            sync_prev <= sync_2;
            pulse     <= sync_2 & ~sync_prev;
        end
    end

endmodule

// File: rtl/sample_playback_engine.sv
// Streams one clip of signed samples from flash to the DAC, one sample
// per divided sample-clock tick, four samples per 32-bit flash word.
// Optional build macro: UNDERRUN_CNT_EN adds the underrun_count output.
module sample_playback_engine
    import playback_pkg::*;
#(
    parameter int unsigned ADDR_W   = 23,
    parameter int unsigned SAMPLE_W = 8
) (
    input  logic                               clock_in,
    input  logic                               reset,
    input  logic                               sample_clk,
    input  logic                               start,
    input  logic                               stop,
    input  logic [ADDR_W-1:0]                  start_addr,
    input  logic [ADDR_W-1:0]                  end_addr,
    output logic                               busy,
    output logic                               done,
    output logic                               flash_read,
    output logic [ADDR_W-1:0]                  flash_addr,
    input  logic                               flash_waitrequest,
    input  logic [SAMPLES_PER_WORD*SAMPLE_W-1:0] flash_readdata,
    input  logic                               flash_readdatavalid,
    output logic [SAMPLE_W-1:0]                audio_out,
    output logic                               audio_valid
`ifdef UNDERRUN_CNT_EN
    ,
    output logic [UNDERRUN_W-1:0]              underrun_count
`endif
);

    localparam int unsigned IDX_W = $clog2(SAMPLES_PER_WORD);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES_PER_WORD - 1);

    typedef logic [SAMPLES_PER_WORD-1:0][SAMPLE_W-1:0] word_t;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   addr, addr_n;
    logic [ADDR_W-1:0]   end_reg, end_n;
    word_t               word, word_n;
    logic [IDX_W-1:0]    byte_idx, byte_idx_n;
    logic                abort, abort_n;
    logic [SAMPLE_W-1:0] audio_out_n;
    logic                audio_valid_n;
    logic                done_n;
    logic                busy_n;
    logic                flash_read_n;
    logic [ADDR_W-1:0]   flash_addr_n;
    logic                tick;

    edge_sync_detect u_tick (
        .clock_in (clock_in),
        .reset    (reset),
        .async_in (sample_clk),
        .pulse    (tick)
    );

    // State register and registered outputs.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state       <= IDLE;
            addr        <= '0;
            end_reg     <= '0;
            word        <= '0;
            byte_idx    <= '0;
            abort       <= 1'b0;
            audio_out   <= '0;
            audio_valid <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
            flash_read  <= 1'b0;
            flash_addr  <= '0;
        end else begin
            state       <= state_n;
            addr        <= addr_n;
            end_reg     <= end_n;
            word        <= word_n;
            byte_idx    <= byte_idx_n;
            abort       <= abort_n;
            audio_out   <= audio_out_n;
            audio_valid <= audio_valid_n;
            done        <= done_n;
            busy        <= busy_n;
            flash_read  <= flash_read_n;
            flash_addr  <= flash_addr_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n       = state;
        addr_n        = addr;
        end_n         = end_reg;
        word_n        = word;
        byte_idx_n    = byte_idx;
        abort_n       = abort;
        audio_out_n   = audio_out;
        audio_valid_n = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    addr_n  = start_addr;
                    end_n   = end_addr;
                    abort_n = 1'b0;
                    state_n = (start_addr > end_addr) ? DONE : REQ;
                end
            end

            REQ: begin
                // An abort must still complete the handshake already on the bus.
                if (stop) begin
                    abort_n = 1'b1;
                end
                if (!flash_waitrequest) begin
                    state_n = (abort || stop) ? DRAIN : WAIT_DATA;
                end
            end

            WAIT_DATA: begin
                if (stop) begin
                    // Data arriving with the stop needs no draining.
                    state_n = flash_readdatavalid ? DONE : DRAIN;
                end else if (flash_readdatavalid) begin
                    word_n     = word_t'(flash_readdata);
                    byte_idx_n = '0;
                    state_n    = PLAY;
                end
            end

            PLAY: begin
                if (tick) begin
                    audio_out_n   = word[byte_idx];
                    audio_valid_n = 1'b1;
                    byte_idx_n    = byte_idx + 1'b1;
                    if (byte_idx == LAST_IDX) begin
                        if (stop || (addr == end_reg)) begin
                            state_n = DONE;
                        end else begin
                            addr_n  = addr + 1'b1;
                            state_n = REQ;
                        end
                    end else if (stop) begin
                        state_n = DONE;
                    end
                end else if (stop) begin
                    state_n = DONE;
                end
            end

            DRAIN: begin
                if (flash_readdatavalid) begin
                    state_n = DONE;
                end
            end

            DONE: begin
                audio_out_n = SAMPLE_W'(SILENCE);
                state_n     = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        flash_read_n = (state_n == REQ);
        flash_addr_n = (state_n == REQ) ? addr_n : flash_addr;
        busy_n       = (state_n != IDLE);
        done_n       = (state_n == DONE);
    end

`ifdef UNDERRUN_CNT_EN
    // Count ticks that arrive while no sample is available; saturates.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            underrun_count <= '0;
        end else if ((state == IDLE) && start) begin
            underrun_count <= '0;
        end else if (tick && ((state == REQ) || (state == WAIT_DATA))
                     && (underrun_count != {UNDERRUN_W{1'b1}})) begin
            underrun_count <= underrun_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sample_playback_engine.sv
// Directed bench for sample_playback_engine with a behavioural flash slave.
module tb_sample_playback_engine;

    localparam int unsigned ADDR_W   = 23;
    localparam int unsigned SAMPLE_W = 8;

    logic                clock_in = 1'b0;
    logic                reset;
    logic                sample_clk = 1'b0;
    logic                start;
    logic                stop;
    logic [ADDR_W-1:0]   start_addr;
    logic [ADDR_W-1:0]   end_addr;
    logic                busy;
    logic                done;
    logic                flash_read;
    logic [ADDR_W-1:0]   flash_addr;
    logic                flash_waitrequest;
    logic [31:0]         flash_readdata = '0;
    logic                flash_readdatavalid = 1'b0;
    logic [SAMPLE_W-1:0] audio_out;
    logic                audio_valid;
`ifdef UNDERRUN_CNT_EN
    logic [15:0]         underrun_count;
`endif

    int tests = 0;
    int fails = 0;

    // Flash model controls.
    int wr_stall  = 0;
    int rdv_delay = 0;
    int stall_cnt = 0;
    logic pend = 1'b0;
    int pend_cnt = 0;
    logic [ADDR_W-1:0] pend_addr = '0;

    // Sample clock generator controls: 0 hold, 1 free run, 2 run until target rising edges.
    int sclk_mode   = 0;
    int sclk_half   = 4;
    int sclk_made   = 0;
    int sclk_target = 0;
    int sclk_cnt    = 0;

    always #5 clock_in = ~clock_in;

    sample_playback_engine #(.ADDR_W(ADDR_W), .SAMPLE_W(SAMPLE_W)) dut (
        .clock_in            (clock_in),
        .reset               (reset),
        .sample_clk          (sample_clk),
        .start               (start),
        .stop                (stop),
        .start_addr          (start_addr),
        .end_addr            (end_addr),
        .busy                (busy),
        .done                (done),
        .flash_read          (flash_read),
        .flash_addr          (flash_addr),
        .flash_waitrequest   (flash_waitrequest),
        .flash_readdata      (flash_readdata),
        .flash_readdatavalid (flash_readdatavalid),
        .audio_out           (audio_out),
        .audio_valid         (audio_valid)
`ifdef UNDERRUN_CNT_EN
        ,
        .underrun_count      (underrun_count)
`endif
    );

    function automatic logic [31:0] word_for(input logic [ADDR_W-1:0] a);
        logic [7:0] b;
        b = a[7:0];
        case (a)
            23'h10:  return 32'h44332211;
            23'h11:  return 32'h88776655;
            default: return {b + 8'd3, b + 8'd2, b + 8'd1, b};
        endcase
    endfunction

    assign flash_waitrequest = flash_read && (stall_cnt < wr_stall);

    // Flash slave: stalls wr_stall cycles, returns data rdv_delay+1 cycles after acceptance.
    always @(posedge clock_in) begin
        flash_readdatavalid <= 1'b0;
        if (pend && pend_cnt == 0) begin
            flash_readdatavalid <= 1'b1;
            flash_readdata      <= word_for(pend_addr);
            pend                <= 1'b0;
        end else if (pend) begin
            pend_cnt <= pend_cnt - 1;
        end
        if (flash_read && !flash_waitrequest) begin
            pend      <= 1'b1;
            pend_cnt  <= rdv_delay;
            pend_addr <= flash_addr;
            stall_cnt <= 0;
        end else if (flash_read) begin
            stall_cnt <= stall_cnt + 1;
        end
    end

    // Sample clock generator.
    always @(posedge clock_in) begin
        if (sclk_mode == 1 || (sclk_mode == 2 && sclk_made < sclk_target)) begin
            sclk_cnt = sclk_cnt + 1;
            if (sclk_cnt >= sclk_half) begin
                sclk_cnt = 0;
                if (!sample_clk) sclk_made = sclk_made + 1;
                sample_clk <= ~sample_clk;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [ADDR_W-1:0] sa;
        logic [ADDR_W-1:0] ea;
        int                n;
        logic [63:0]       exp;
        string             name;
    } clip_vec_t;

    clip_vec_t vecs[4];

    // Start a clip, collect strobed samples until done, then check the idle cycle.
    task automatic run_clip(input clip_vec_t v);
        int got, dones, reads, done_at;
        logic [7:0] e;
        got = 0; dones = 0; reads = 0; done_at = -1;
        start_addr = v.sa;
        end_addr   = v.ea;
        start      = 1'b1;
        for (int c = 0; c < 3000 && dones == 0; c++) begin
            @(posedge clock_in); #1;
            if (c == 0) begin
                start = 1'b0;
                chk({v.name, "_busy"}, 32'(busy), 32'd1);
            end
            if (flash_read) reads++;
            if (audio_valid) begin
                if (got < 8) begin
                    e = v.exp[8*got +: 8];
                    chk($sformatf("%s_sample%0d", v.name, got), 32'(audio_out), 32'(e));
                end
                got++;
            end
            if (done) begin
                dones++;
                done_at = c;
            end
        end
        chk({v.name, "_done_seen"}, 32'(dones), 32'd1);
        chk({v.name, "_count"}, 32'(got), 32'(v.n));
        if (v.n == 0) begin
            chk({v.name, "_no_read"}, 32'(reads), 32'd0);
            chk({v.name, "_done_fast"}, 32'(done_at <= 1), 32'd1);
        end
        @(posedge clock_in); #1;
        chk({v.name, "_done_single"}, 32'(done), 32'd0);
        chk({v.name, "_busy_low"}, 32'(busy), 32'd0);
        chk({v.name, "_silence"}, 32'(audio_out), 32'd0);
    endtask

    initial begin
        int got, dones, rd_cycles, valids, reads_after;
        logic addr_ok, held;
        clip_vec_t v;

        vecs[0] = '{sa: 23'h10,     ea: 23'h11,     n: 8, exp: 64'h8877665544332211, name: "two_words"};
        vecs[1] = '{sa: 23'h20,     ea: 23'h1F,     n: 0, exp: 64'h0,                name: "empty"};
        vecs[2] = '{sa: 23'h30,     ea: 23'h30,     n: 4, exp: 64'h33323130,         name: "one_word"};
        vecs[3] = '{sa: 23'h7FFFFF, ea: 23'h7FFFFF, n: 4, exp: 64'h020100FF,         name: "top_addr"};

        reset = 1'b1; start = 1'b0; stop = 1'b0; start_addr = '0; end_addr = '0;
        repeat (3) @(posedge clock_in);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_flash_read", 32'(flash_read), 32'd0);
        chk("rst_flash_addr", 32'(flash_addr), 32'd0);
        chk("rst_audio_out", 32'(audio_out), 32'd0);
        chk("rst_audio_valid", 32'(audio_valid), 32'd0);
        reset = 1'b0;

        // Table-driven clips with a free-running sample clock at clock/8.
        sclk_half = 4; sclk_mode = 1;
        for (int i = 0; i < 4; i++) begin
            run_clip(vecs[i]);
            repeat (5) @(posedge clock_in);
            #1;
        end

        // Waitrequest held for 5 cycles: request must stay stable, accepted on the 6th.
        wr_stall = 5;
        start_addr = 23'h40; end_addr = 23'h40; start = 1'b1;
        rd_cycles = 0; addr_ok = 1'b1; got = 0; dones = 0;
        for (int c = 0; c < 3000 && dones == 0; c++) begin
            @(posedge clock_in); #1;
            if (c == 0) start = 1'b0;
            if (flash_read) begin
                rd_cycles++;
                if (flash_addr !== 23'h40) addr_ok = 1'b0;
            end
            if (audio_valid) got++;
            if (done) dones++;
        end
        chk("wr_read_cycles", 32'(rd_cycles), 32'd6);
        chk("wr_addr_stable", 32'(addr_ok), 32'd1);
        chk("wr_samples", 32'(got), 32'd4);
        chk("wr_done", 32'(dones), 32'd1);
        wr_stall = 0;

        // Late read data with ticks every 4 cycles: exactly 5 ticks land before the data.
        sclk_mode = 0;
        repeat (10) @(posedge clock_in);
        #1;
        rdv_delay = 30;
        sclk_half = 2; sclk_target = sclk_made + 5; sclk_mode = 2;
        start_addr = 23'h50; end_addr = 23'h50; start = 1'b1;
        valids = 0; held = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(posedge clock_in); #1;
            if (c == 0) start = 1'b0;
            if (audio_valid) valids++;
            if (audio_out !== 8'h00) held = 1'b0;
        end
        chk("ur_no_strobe", 32'(valids), 32'd0);
        chk("ur_out_held", 32'(held), 32'd1);
        sclk_target = sclk_made + 4;
        got = 0; dones = 0;
        for (int c = 0; c < 200 && dones == 0; c++) begin
            @(posedge clock_in); #1;
            if (audio_valid) begin
                chk($sformatf("ur_sample%0d", got), 32'(audio_out), 32'h50 + 32'(got));
                got++;
            end
            if (done) dones++;
        end
        chk("ur_samples", 32'(got), 32'd4);
        chk("ur_done", 32'(dones), 32'd1);
`ifdef UNDERRUN_CNT_EN
        chk("ur_count", 32'(underrun_count), 32'd5);
`endif
        rdv_delay = 0;

        // Stop while waiting for read data: late data discarded, one done pulse.
        sclk_half = 4; sclk_mode = 1; rdv_delay = 10;
        repeat (3) @(posedge clock_in);
        #1;
        start_addr = 23'h60; end_addr = 23'h61; start = 1'b1;
        valids = 0; dones = 0; rd_cycles = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clock_in); #1;
            if (c == 0) start = 1'b0;
            stop = 1'b0;
            if (flash_read) rd_cycles++;
            if (c == 3) stop = 1'b1;
            if (audio_valid) valids++;
            if (done) dones++;
        end
        chk("stop_reads", 32'(rd_cycles), 32'd1);
        chk("stop_no_strobe", 32'(valids), 32'd0);
        chk("stop_done_once", 32'(dones), 32'd1);
        chk("stop_busy_low", 32'(busy), 32'd0);
        reads_after = 0;
        rdv_delay = 0;

        // Reset in the middle of playback, then a fresh clip.
        start_addr = 23'h10; end_addr = 23'h11; start = 1'b1;
        got = 0;
        for (int c = 0; c < 500 && got < 2; c++) begin
            @(posedge clock_in); #1;
            if (c == 0) start = 1'b0;
            if (audio_valid) got++;
        end
        chk("mid_samples", 32'(got), 32'd2);
        reset = 1'b1;
        @(posedge clock_in); #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_read", 32'(flash_read), 32'd0);
        chk("mid_rst_addr", 32'(flash_addr), 32'd0);
        chk("mid_rst_audio", 32'(audio_out), 32'd0);
        chk("mid_rst_valid", 32'(audio_valid), 32'd0);
        reset = 1'b0;
        repeat (20) @(posedge clock_in);
        #1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clock_in); #1;
            if (busy || flash_read || audio_valid) reads_after++;
        end
        chk("mid_rst_quiet", 32'(reads_after), 32'd0);
        v = vecs[2];
        v.name = "after_rst";
        run_clip(v);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
